// File: rtl/dmem_responder.sv
// Synthesizable data-memory responder: one command per cycle, tagged responses,
// fixed-latency load completions drawn from a small pool of outstanding-load slots.
module dmem_responder #(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_SLOTS   = 4,
  parameter int ADDR_W      = 12,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [63:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_bits;

  logic              slot_valid [NUM_SLOTS];
  logic [3:0]        slot_tag   [NUM_SLOTS];
  logic [CNT_W-1:0]  slot_cnt   [NUM_SLOTS];
  logic [63:0]       slot_data  [NUM_SLOTS];

  logic [3:0]        next_tag;
  logic              free_found;
  logic [SLOT_W-1:0] free_slot;
  logic              load_ok;
  logic              store_ok;
  logic              accept;

  assign idx = proc2mem_addr[ADDR_W+2:3];
  assign unused_addr_bits = ^{proc2mem_addr[XLEN-1:ADDR_W+3], proc2mem_addr[2:0]};

  // A slot whose counter is at 1 retires on this edge, so it may be handed to a new load.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i] || slot_cnt[i] == CNT_W'(1)) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  assign load_ok  = !reset && proc2mem_command == CMD_LOAD && free_found;
  assign store_ok = !reset && proc2mem_command == CMD_STORE;
  assign accept   = load_ok || store_ok;
  assign mem2proc_response = accept ? next_tag : 4'd0;

  always_ff @(posedge clock) begin
    if (store_ok) begin
      mem[idx] <= proc2mem_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      next_tag      <= 4'd1;
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 64'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_valid[i] <= 1'b0;
        slot_tag[i]   <= 4'd0;
        slot_cnt[i]   <= '0;
        slot_data[i]  <= 64'd0;
      end
    end else begin
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 64'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_valid[i]) begin
          if (slot_cnt[i] == CNT_W'(1)) begin
            slot_valid[i] <= 1'b0;
            mem2proc_tag  <= slot_tag[i];
            mem2proc_data <= slot_data[i];
          end else begin
            slot_cnt[i] <= slot_cnt[i] - CNT_W'(1);
          end
        end
      end
      // Placed after the retire loop so a reused slot takes the new load.
      if (load_ok) begin
        slot_valid[free_slot] <= 1'b1;
        slot_tag[free_slot]   <= next_tag;
        slot_cnt[free_slot]   <= CNT_W'(MEM_LATENCY);
        slot_data[free_slot]  <= mem[idx];
      end
      if (accept) begin
        next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized run,
// all checked against a queue-based model of outstanding loads and a word-indexed memory.
module tb_dmem_responder;

  localparam int L  = 4;
  localparam int NS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [63:0] wdata = 64'd0;
  logic [3:0]  resp;
  logic [3:0]  tag;
  logic [63:0] rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] mem_m [int];
  int          edge_n = 0;
  logic [3:0]  tag_m = 4'd1;

  always #5 clock = ~clock;

  dmem_responder #(.MEM_LATENCY(L), .NUM_SLOTS(NS), .ADDR_W(12), .XLEN(32)) dut (
    .clock(clock),
    .reset(reset),
    .proc2mem_command(cmd),
    .proc2mem_addr(addr),
    .proc2mem_data(wdata),
    .mem2proc_response(resp),
    .mem2proc_data(rdata),
    .mem2proc_tag(tag)
  );

  function automatic int word_of(input logic [31:0] a);
    return int'(a[14:3]);
  endfunction

  // One cycle: apply a command, predict its response and the completion seen after the edge.
  task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                       output logic [3:0] o_resp, output logic [3:0] e_resp,
                       output logic [3:0] o_tag, output logic [3:0] e_tag,
                       output logic [63:0] o_data, output logic [63:0] e_data);
    int busy;
    bit acc;
    int w;
    cmd = c; addr = a; wdata = d;
    #1;
    o_resp = resp;
    w = word_of(a);
    acc = 1'b0;
    if (c == 2'd2) acc = 1'b1;
    else if (c == 2'd1) begin
      busy = 0;
      foreach (pend[i]) if (pend[i].due > edge_n + 1) busy++;
      acc = (busy < NS);
    end
    e_resp = acc ? tag_m : 4'd0;
    @(posedge clock);
    edge_n++;
    if (acc) begin
      if (c == 2'd2) mem_m[w] = d;
      else pend.push_back('{due: edge_n + L, tag: tag_m,
                            data: (mem_m.exists(w) ? mem_m[w] : 64'd0)});
      tag_m = (tag_m == 4'd15) ? 4'd1 : tag_m + 4'd1;
    end
    e_tag = 4'd0;
    e_data = 64'd0;
    foreach (pend[i]) if (pend[i].due == edge_n) begin
      e_tag = pend[i].tag;
      e_data = pend[i].data;
    end
    while (pend.size() > 0 && pend[0].due <= edge_n) void'(pend.pop_front());
    #1;
    o_tag = tag;
    o_data = rdata;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cmd = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pend.delete();
    tag_m = 4'd1;
  endtask

  task automatic test_reset();
    cmd = 2'd1;
    addr = 32'h0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (resp !== 4'd0) begin
      failures++;
      $display("FAIL reset_resp got %0d expected 0", resp);
    end
    checks++;
    if (tag !== 4'd0 || rdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs tag=%0d data=%h expected tag 0 data 0", tag, rdata);
    end
    @(negedge clock);
    reset = 1'b0;
    cmd = 2'd0;
    pend.delete();
    tag_m = 4'd1;
  endtask

  task automatic test_store_load();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    drive(2'd2, 32'h08, 64'hDEADBEEF_00000001, r, er, t, et, d, ed);
    checks++;
    if (r !== er || r !== 4'd1) begin
      failures++;
      $display("FAIL store_resp got %0d expected 1", r);
    end
    drive(2'd1, 32'h08, 64'd0, r, er, t, et, d, ed);
    checks++;
    if (r !== er || r !== 4'd2) begin
      failures++;
      $display("FAIL load_resp got %0d expected 2", r);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(2'd0, 32'h0, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (t !== et || d !== ed) begin
        failures++;
        $display("FAIL load_latency cycle %0d got tag=%0d data=%h expected tag=%0d data=%h", i, t, d, et, ed);
      end
      if (i == 4) begin
        checks++;
        if (t !== 4'd2 || d !== 64'hDEADBEEF_00000001) begin
          failures++;
          $display("FAIL load_data got tag=%0d data=%h expected tag=2 data=deadbeef00000001", t, d);
        end
      end
    end
  endtask

  task automatic preload();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    for (int w = 0; w < 16; w++) begin
      drive(2'd2, 32'(w) << 3, (w == 4) ? 64'h5 : {32'hA5A50000 + 32'(w), 32'($urandom)},
            r, er, t, et, d, ed);
      checks++;
      if (r !== er) begin
        failures++;
        $display("FAIL preload_resp word %0d got %0d expected %0d", w, r, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    bit got5;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, 32'(i) << 3, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (r !== er || r !== 4'(i + 1)) begin
        failures++;
        $display("FAIL b2b_resp load %0d got %0d expected %0d", i, r, i + 1);
      end
    end
    got5 = 1'b0;
    for (int k = 0; k < 10 && !got5; k++) begin
      drive(2'd1, 32'h20, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (r !== er || t !== et || d !== ed) begin
        failures++;
        $display("FAIL b2b_fifth got resp=%0d tag=%0d expected resp=%0d tag=%0d", r, t, er, et);
      end
      if (r != 4'd0) got5 = 1'b1;
    end
    checks++;
    if (!got5) begin
      failures++;
      $display("FAIL b2b_fifth_timeout got no acceptance expected response 5");
    end
    for (int i = 0; i < L + 2; i++) begin
      drive(2'd0, 32'h0, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (t !== et || d !== ed) begin
        failures++;
        $display("FAIL b2b_completion got tag=%0d data=%h expected tag=%0d data=%h", t, d, et, ed);
      end
    end
  endtask

  task automatic test_capture();
    logic [3:0] r, er, t, et, first_tag, second_tag;
    logic [63:0] d, ed;
    drive(2'd1, 32'h20, 64'd0, r, er, t, et, d, ed);
    first_tag = r;
    drive(2'd2, 32'h20, 64'h7, r, er, t, et, d, ed);
    checks++;
    if (r !== er) begin
      failures++;
      $display("FAIL capture_store_resp got %0d expected %0d", r, er);
    end
    second_tag = 4'd0;
    for (int i = 0; i < 2 * L + 4; i++) begin
      drive((i == L) ? 2'd1 : 2'd0, 32'h20, 64'd0, r, er, t, et, d, ed);
      if (i == L) second_tag = r;
      checks++;
      if (t !== et || d !== ed) begin
        failures++;
        $display("FAIL capture_completion got tag=%0d data=%h expected tag=%0d data=%h", t, d, et, ed);
      end
      if (t == first_tag && t != 4'd0) begin
        checks++;
        if (d !== 64'h5) begin
          failures++;
          $display("FAIL capture_old got %h expected 5", d);
        end
      end
      if (t == second_tag && t != 4'd0) begin
        checks++;
        if (d !== 64'h7) begin
          failures++;
          $display("FAIL capture_new got %h expected 7", d);
        end
      end
    end
  endtask

  task automatic test_tag_wrap();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(2'd2, {17'($urandom), 8'd0, 4'($urandom_range(0, 15)), 3'($urandom)},
            {32'h0, 32'($urandom)}, r, er, t, et, d, ed);
      checks++;
      if (r !== er || r !== 4'((i % 15) + 1)) begin
        failures++;
        $display("FAIL tag_wrap cmd %0d got %0d expected %0d", i, r, (i % 15) + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    apply_reset();
    drive(2'd1, 32'h00, 64'd0, r, er, t, et, d, ed);
    drive(2'd1, 32'h08, 64'd0, r, er, t, et, d, ed);
    drive(2'd0, 32'h00, 64'd0, r, er, t, et, d, ed);
    drive(2'd0, 32'h00, 64'd0, r, er, t, et, d, ed);
    reset = 1'b1;
    cmd = 2'd1;
    #1;
    checks++;
    if (resp !== 4'd0 || tag !== 4'd0 || rdata !== 64'd0) begin
      failures++;
      $display("FAIL midreset_outputs got resp=%0d tag=%0d data=%h expected all 0", resp, tag, rdata);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cmd = 2'd0;
    pend.delete();
    tag_m = 4'd1;
    for (int i = 0; i < L + 2; i++) begin
      drive(2'd0, 32'h0, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (t !== 4'd0) begin
        failures++;
        $display("FAIL midreset_dropped got tag=%0d expected 0", t);
      end
    end
    drive(2'd1, 32'h10, 64'd0, r, er, t, et, d, ed);
    checks++;
    if (r !== 4'd1) begin
      failures++;
      $display("FAIL midreset_first_tag got %0d expected 1", r);
    end
    for (int i = 0; i < L + 1; i++) begin
      drive(2'd0, 32'h0, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (t !== et || d !== ed) begin
        failures++;
        $display("FAIL midreset_survive got tag=%0d data=%h expected tag=%0d data=%h", t, d, et, ed);
      end
    end
  endtask

  task automatic test_alias_cmd3();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    drive(2'd3, 32'h08, 64'hFFFF, r, er, t, et, d, ed);
    checks++;
    if (r !== 4'd0 || er !== 4'd0) begin
      failures++;
      $display("FAIL cmd3_resp got %0d expected 0", r);
    end
    drive(2'd1, 32'h0C, 64'd0, r, er, t, et, d, ed);
    checks++;
    if (r !== er) begin
      failures++;
      $display("FAIL cmd3_no_tag_advance got %0d expected %0d", r, er);
    end
    drive(2'd2, 32'h0C, 64'h1234_5678_9ABC_DEF0, r, er, t, et, d, ed);
    drive(2'd1, 32'h08, 64'd0, r, er, t, et, d, ed);
    for (int i = 0; i < L + 2; i++) begin
      drive(2'd0, 32'h0, 64'd0, r, er, t, et, d, ed);
      checks++;
      if (t !== et || d !== ed) begin
        failures++;
        $display("FAIL alias_completion got tag=%0d data=%h expected tag=%0d data=%h", t, d, et, ed);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r, er, t, et;
    logic [63:0] d, ed;
    logic [1:0] c;
    logic [31:0] a;
    logic [63:0] dat;
    bit hold;
    hold = 1'b0;
    c = 2'd0; a = 32'd0; dat = 64'd0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        c = 2'($urandom_range(0, 3));
        a = {17'($urandom), 8'd0, 4'($urandom_range(0, 15)), 3'($urandom)};
        dat = {32'($urandom), 32'($urandom)};
      end
      drive(c, a, dat, r, er, t, et, d, ed);
      hold = (c == 2'd1 && r == 4'd0);
      checks++;
      if (r !== er || t !== et || d !== ed) begin
        failures++;
        $display("FAIL random step %0d got resp=%0d tag=%0d data=%h expected resp=%0d tag=%0d data=%h",
                 i, r, t, d, er, et, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    preload();
    test_back_to_back();
    test_capture();
    test_tag_wrap();
    test_reset_mid();
    test_alias_cmd3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
